ts_packet_scheduler: RTL

Round-robin packet scheduler sitting between the four per-tuner packet buffers and the 54 MHz-side output FIFO. It grants whole 188-byte TS packets to channels that have a complete packet buffered and are enabled by SPI configuration. It serializes the granted packet onto a single byte stream with sync/valid framing. When no channel is eligible, it optionally inserts null packets (PID 0x1FFF) to keep the output rate constant.

---
 rtl/ts_packet_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ts_packet_scheduler.sv
// Round-robin TS packet scheduler: grants whole packets from four tuner buffers
// and serializes them onto one framed byte stream, padding with null packets.
module ts_packet_scheduler #(
  parameter int unsigned PKT_LEN = 188,
  parameter bit          NULL_EN = 1'b1
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic [3:0] CH_ENABLE,
  input  logic [3:0] GOT_FULL_PACKET,
  input  logic [7:0] DATA_IN_0,
  input  logic [7:0] DATA_IN_1,
  input  logic [7:0] DATA_IN_2,
  input  logic [7:0] DATA_IN_3,
  input  logic       OUT_READY,
  output logic [3:0] GIVE_ME_ONE_PACKET,
  output logic [7:0] DATA_OUT,
  output logic       D_VALID_OUT,
  output logic       P_SYNC_OUT,
  output logic [1:0] CUR_CH,
  output logic       NULL_INS,
  output logic       SYNC_ERR
);

  typedef enum logic [1:0] {IDLE, GRANT, SEND} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [1:0] last_grant, sel, pick, idx;
  logic       found, go, null_mode, last_byte;
  logic [3:0] elig;
  logic [7:0] src_byte, null_byte;

  assign elig      = CH_ENABLE & GOT_FULL_PACKET;
  assign go        = OUT_READY && (found || NULL_EN);
  assign last_byte = (cnt == 8'(PKT_LEN - 1));

  // Search starts one past the last real grant; i=4 wraps back to last_grant itself.
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    case (sel)
      2'd0:    src_byte = DATA_IN_0;
      2'd1:    src_byte = DATA_IN_1;
      2'd2:    src_byte = DATA_IN_2;
      default: src_byte = DATA_IN_3;
    endcase
  end

  always_comb begin
    case (cnt)
      8'd0:    null_byte = 8'h47;
      8'd1:    null_byte = 8'h1F;
      8'd2:    null_byte = 8'hFF;
      8'd3:    null_byte = 8'h10;
      default: null_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = GRANT;
      GRANT:   state_nxt = SEND;
      SEND:    if (last_byte) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      cnt                <= '0;
      last_grant         <= 2'd3;
      sel                <= '0;
      null_mode          <= 1'b0;
      GIVE_ME_ONE_PACKET <= '0;
    end else begin
      GIVE_ME_ONE_PACKET <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          // Grant register is loaded here so the pulse coincides with the GRANT state.
          if (go) begin
            null_mode <= !found;
            if (found) begin
              sel                <= pick;
              last_grant         <= pick;
              GIVE_ME_ONE_PACKET <= 4'(1) << pick;
            end
          end
        end
        SEND:    cnt <= cnt + 8'd1;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      DATA_OUT    <= '0;
      D_VALID_OUT <= 1'b0;
      P_SYNC_OUT  <= 1'b0;
      NULL_INS    <= 1'b0;
      SYNC_ERR    <= 1'b0;
      CUR_CH      <= '0;
    end else begin
      D_VALID_OUT <= (state == SEND);
      P_SYNC_OUT  <= (state == SEND) && (cnt == 8'd0);
      NULL_INS    <= (state == SEND) && null_mode;
      SYNC_ERR    <= (state == SEND) && (cnt == 8'd0) && !null_mode && (src_byte != 8'h47);
      if (state == SEND) begin
        DATA_OUT <= null_mode ? null_byte : src_byte;
        if (cnt == 8'd0 && !null_mode) CUR_CH <= sel;
      end
    end
  end

endmodule
